multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Phase sequencer for the multi-cycle RV64 core. It owns the program counter, the instruction register and the five-phase FSM (IF, ID, EX, MEM, WB). It steps the instruction memory, decoder, ALU and data memory one phase per clock, and stalls in MEM on a data-memory handshake. Branch outcomes from the decoder are resolved into the next PC at WB. The block replaces the free-running 3-bit phase counter with an explicit, stallable and haltable controller.

## Interface
- IMEM_DEPTH, 32, instruction words in instruction memory; must equal 2**ADDR_W
- ADDR_W, 5, PC width (word index)
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high; sampled on posedge clk, overrides every other input
- imem_addr  out  ADDR_W  word address, equal to pc
- imem_rd_en  out  1  high in IF
- imem_rdata  in  32  combinational read data for imem_addr
- ir  out  32  latched instruction, stable from ID through WB
- phase  out  5  one-hot: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB; all zero in HALT
- branch  in  1  decoder branch-condition result, valid in EX
- branch_sel  in  3  0 beq, 1 bne, 2 blt, 3 bge, 7 none; valid in EX
- offset  in  64  signed word offset from the decoder, valid in EX
- is_mem  in  1  decoded load/store, valid from ID through WB
- mem_req  out  1  data-memory request, high in MEM when is_mem
- mem_ready  in  1  data-memory completion
- halt  out  1  sticky, high in HALT
- retired  out  32  count of instructions that completed WB

## Operation
- States are IF, ID, EX, MEM, WB and HALT. Outputs decode combinationally from the state and registers.
- On reset: state=IF, pc=0, ir=0, taken=0, retired=0.
  - Resulting output values: imem_rd_en=1, imem_addr=0, phase=5'b00001, mem_req=0, halt=0.
- IF to ID: ir <= imem_rdata.
  - If imem_rdata==32'h0, go to HALT instead. ir is still loaded and retired is unchanged.
- ID to EX: unconditional.
- EX to MEM: taken <= branch && (branch_sel <= 3).
  - branch_sel values 4 to 7 never redirect the PC, even when branch=1.
- MEM: mem_req = is_mem.
  - Stay in MEM while is_mem && !mem_ready.
  - Leave for WB on the edge where mem_ready=1, or immediately when is_mem=0.
- WB to IF:
  - pc <= taken ? pc + offset[ADDR_W-1:0] : pc + 1, with modulo-2**ADDR_W wrap. Low-bit truncation of the two's-complement offset gives correct wrap.
  - retired <= retired + 1, wrapping at 2**32.
- HALT is absorbing until rst. In HALT, imem_rd_en=0, mem_req=0 and phase=0.
- rst in any state, including MEM with mem_req=1, returns to IF on the next edge. The in-flight instruction is abandoned and is not retired.

## Timing
- A non-memory instruction takes exactly 5 cycles, IF to IF.
- A memory instruction takes 5 + N cycles, where N is the number of MEM cycles with mem_ready=0.
- imem_addr changes only on the WB to IF edge, and reset.
- ir changes only on the IF edge.
- mem_ready asserted outside MEM is ignored.
- mem_ready=1 in the first MEM cycle gives no stall.
- Offset 0 with a branch taken re-fetches the same PC (a legal loop).

## Structure
- Shared package riscv_ctrl_pkg holds:
  - the state encoding constants;
  - the branch_sel codes BR_BEQ=0, BR_BNE=1, BR_BLT=2, BR_BGE=3, BR_NONE=7;
  - the HALT_INSTR=32'h0 constant.
- One combinational sub-module, pc_next_unit, takes pc, taken and offset and produces the next pc. The FSM, ir, the taken register and the retired counter stay in multicycle_ctrl.

## Test plan
- Reset, then a program of three non-memory instructions followed by a zero word:
  - imem_addr is 0 at cycle 0, 1 at cycle 5 and 2 at cycle 10;
  - retired=3 at cycle 15;
  - halt=1 from cycle 16, with phase=0.
- beq with branch=1 and offset=-2 at pc=4: the next IF has imem_addr=2. The same with branch=0: imem_addr=5.
- branch=1 with branch_sel=7, and separately branch_sel=5: the next pc is pc+1.
- Load with mem_ready low for 3 MEM cycles: mem_req is high for 4 cycles and the instruction occupies 8 cycles. mem_ready pulses during EX are ignored.
- Wrap cases:
  - sequential from pc=31 gives 0;
  - taken with offset=+5 at pc=30 gives 3;
  - offset=-33 at pc=0 gives 31.
- rst asserted during a MEM stall:
  - the next cycle shows phase=5'b00001, pc=0, mem_req=0, retired=0;
  - rst asserted in HALT clears halt.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64 phase sequencer:
// FSM state encoding, decoder branch_sel codes and the halt word.
package riscv_ctrl_pkg;

  // Controller states. HALT is absorbing until reset.
  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // branch_sel codes produced by the decoder.
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_NONE = 3'd7;

  // An all-zero instruction word stops the sequencer.
  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

  // One-hot phase bits presented to the datapath.
  localparam logic [4:0] PH_IF   = 5'b00001;
  localparam logic [4:0] PH_ID   = 5'b00010;
  localparam logic [4:0] PH_EX   = 5'b00100;
  localparam logic [4:0] PH_MEM  = 5'b01000;
  localparam logic [4:0] PH_WB   = 5'b10000;
  localparam logic [4:0] PH_NONE = 5'b00000;

  // Only the four real conditional-branch codes may redirect the PC;
  // codes 4..7 fall through even if the decoder raises branch.
  function automatic logic br_redirect(input logic branch, input logic [2:0] sel);
    return branch && (sel <= BR_BGE);
  endfunction

  // Map a controller state onto its one-hot phase vector.
  function automatic logic [4:0] phase_of(input state_t st);
    logic [4:0] ph;
    case (st)
      ST_IF:   ph = PH_IF;
      ST_ID:   ph = PH_ID;
      ST_EX:   ph = PH_EX;
      ST_MEM:  ph = PH_MEM;
      ST_WB:   ph = PH_WB;
      default: ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bus between the phase sequencer and the instruction memory, decoder
// and data memory. master = sequencer, slave = surrounding datapath.
interface multicycle_ctrl_if #(
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_rd_en;
  logic [31:0]         imem_rdata;
  logic [31:0]         ir;
  logic [4:0]          phase;
  logic                branch;
  logic [2:0]          branch_sel;
  logic signed [63:0]  offset;
  logic                is_mem;
  logic                mem_req;
  logic                mem_ready;
  logic                halt;
  logic [31:0]         retired;

  modport master (
    output imem_addr, imem_rd_en, ir, phase, mem_req, halt, retired,
    input  imem_rdata, branch, branch_sel, offset, is_mem, mem_ready
  );

  modport slave (
    input  imem_addr, imem_rd_en, ir, phase, mem_req, halt, retired,
    output imem_rdata, branch, branch_sel, offset, is_mem, mem_ready
  );

endinterface

// File: rtl/multicycle_ctrl_pc_next.sv
// Next-PC adder: either the sequential successor or the branch target.
// Arithmetic is modulo 2**ADDR_W, so a negative two's-complement offset
// only needs its low ADDR_W bits.
module pc_next_unit #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic               taken,
  input  logic signed [63:0] offset,
  output logic [ADDR_W-1:0]  pc_next
);

  logic [ADDR_W-1:0] step;
  logic              unused_offset_hi;

  // Upper offset bits cannot influence a modulo-2**ADDR_W result.
  assign unused_offset_hi = ^offset[63:ADDR_W];

  // Select the increment and add with natural wrap.
  always_comb begin
    step    = taken ? offset[ADDR_W-1:0] : ADDR_W'(1);
    pc_next = pc + step;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-phase sequencer (IF, ID, EX, MEM, WB) for the multi-cycle core.
// Owns pc, ir, the latched branch decision and the retired counter;
// stalls in MEM on the data-memory handshake and stops on a zero word.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  // The PC indexes the whole instruction memory with no spare codes.
  if (IMEM_DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("multicycle_ctrl: IMEM_DEPTH must equal 2**ADDR_W");
  end

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [31:0]        ir;
  logic               taken;
  logic [31:0]        retired;
  logic               mem_done;

  // MEM completes on the handshake, or at once for non-memory ops.
  assign mem_done = !bus.is_mem || bus.mem_ready;

  pc_next_unit #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc      (pc),
    .taken   (taken),
    .offset  (bus.offset),
    .pc_next (pc_next)
  );

  // Phase FSM with pc, ir, taken and retired updates at their phase edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IF;
      pc      <= '0;
      ir      <= '0;
      taken   <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        ST_IF: begin
          ir    <= bus.imem_rdata;
          state <= (bus.imem_rdata == HALT_INSTR) ? ST_HALT : ST_ID;
        end
        ST_ID: begin
          state <= ST_EX;
        end
        ST_EX: begin
          taken <= br_redirect(bus.branch, bus.branch_sel);
          state <= ST_MEM;
        end
        ST_MEM: begin
          if (mem_done) begin
            state <= ST_WB;
          end
        end
        ST_WB: begin
          pc      <= pc_next;
          retired <= retired + 32'd1;
          state   <= ST_IF;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IF;
        end
      endcase
    end
  end

  // Outputs decode directly from state and registers.
  assign bus.imem_addr  = pc;
  assign bus.imem_rd_en = (state == ST_IF);
  assign bus.ir         = ir;
  assign bus.phase      = phase_of(state);
  assign bus.mem_req    = (state == ST_MEM) && bus.is_mem;
  assign bus.halt       = (state == ST_HALT);
  assign bus.retired    = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against a PC/retire reference model.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  logic [31:0] imem [DEPTH];
  assign bus.imem_rdata = imem[bus.imem_addr];

  multicycle_ctrl #(
    .IMEM_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int pc_m   = 0;
  int ret_m  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_m  = 0;
    ret_m = 0;
    chk("rst_phase",   64'(bus.phase),      64'(5'b00001));
    chk("rst_rd_en",   64'(bus.imem_rd_en), 64'(1));
    chk("rst_addr",    64'(bus.imem_addr),  64'(0));
    chk("rst_mem_req", 64'(bus.mem_req),    64'(0));
    chk("rst_halt",    64'(bus.halt),       64'(0));
    chk("rst_retired", 64'(bus.retired),    64'(0));
    chk("rst_ir",      64'(bus.ir),         64'(0));
  endtask

  // Run one instruction from IF back to IF, checking every cycle.
  task automatic run_instr(input logic br, input logic [2:0] sel, input int off,
                           input logic mem, input int stalls,
                           output int cycles, output int reqs);
    logic [31:0] word;
    logic        tk;
    int          nxt;
    cycles = 0;
    reqs   = 0;
    word   = $urandom | 32'h1;
    imem[pc_m] = word;
    bus.is_mem     = mem;
    bus.mem_ready  = 1'($urandom);
    bus.branch     = 1'($urandom);
    bus.branch_sel = 3'($urandom);
    bus.offset     = 64'($urandom);
    // IF
    chk("if_phase",   64'(bus.phase),      64'(5'b00001));
    chk("if_rd_en",   64'(bus.imem_rd_en), 64'(1));
    chk("if_addr",    64'(bus.imem_addr),  64'(pc_m));
    chk("if_mem_req", 64'(bus.mem_req),    64'(0));
    chk("if_halt",    64'(bus.halt),       64'(0));
    chk("if_retired", 64'(bus.retired),    64'(ret_m));
    tick(); cycles++;
    // ID
    chk("id_phase", 64'(bus.phase),      64'(5'b00010));
    chk("id_ir",    64'(bus.ir),         64'(word));
    chk("id_rd_en", 64'(bus.imem_rd_en), 64'(0));
    bus.mem_ready = 1'($urandom);
    tick(); cycles++;
    // EX: decoder results valid here; mem_ready pulse must be ignored
    chk("ex_phase",   64'(bus.phase),   64'(5'b00100));
    chk("ex_mem_req", 64'(bus.mem_req), 64'(0));
    bus.branch     = br;
    bus.branch_sel = sel;
    bus.offset     = longint'(off);
    bus.mem_ready  = 1'b1;
    tick(); cycles++;
    bus.branch     = ~br;
    bus.branch_sel = 3'($urandom);
    // MEM
    if (mem) begin
      for (int k = 0; k <= stalls; k++) begin
        chk("mem_phase", 64'(bus.phase), 64'(5'b01000));
        chk("mem_req_hi", 64'(bus.mem_req), 64'(1));
        if (bus.mem_req) reqs++;
        bus.mem_ready = (k == stalls);
        tick(); cycles++;
      end
    end else begin
      chk("mem_phase", 64'(bus.phase),   64'(5'b01000));
      chk("mem_req_lo", 64'(bus.mem_req), 64'(0));
      bus.mem_ready = 1'($urandom);
      tick(); cycles++;
    end
    // WB
    chk("wb_phase",   64'(bus.phase),     64'(5'b10000));
    chk("wb_ir",      64'(bus.ir),        64'(word));
    chk("wb_addr",    64'(bus.imem_addr), 64'(pc_m));
    chk("wb_mem_req", 64'(bus.mem_req),   64'(0));
    bus.mem_ready = 1'b0;
    tick(); cycles++;
    tk  = br && (sel <= 3'd3);
    nxt = tk ? pc_m + off : pc_m + 1;
    pc_m  = ((nxt % DEPTH) + DEPTH) % DEPTH;
    ret_m = ret_m + 1;
  endtask

  // Hard stop if something wedges the stimulus.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, req;
    int off;
    logic [2:0] sel;
    for (int i = 0; i < DEPTH; i++) imem[i] = 32'h0000_0013;
    rst = 1'b1;
    bus.branch = 1'b0; bus.branch_sel = BR_NONE; bus.offset = '0;
    bus.is_mem = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    // Three non-memory instructions, then a zero word.
    imem[3] = HALT_INSTR;
    run_instr(1'b0, BR_NONE, 0, 1'b0, 0, cyc, req);
    chk("prog_cyc0", 64'(cyc), 64'(5));
    chk("prog_addr5", 64'(bus.imem_addr), 64'(1));
    run_instr(1'b0, BR_NONE, 0, 1'b0, 0, cyc, req);
    chk("prog_addr10", 64'(bus.imem_addr), 64'(2));
    run_instr(1'b0, BR_NONE, 0, 1'b0, 0, cyc, req);
    imem[3] = HALT_INSTR;
    chk("prog_ret15", 64'(bus.retired), 64'(3));
    chk("prog_addr15", 64'(bus.imem_addr), 64'(3));
    bus.is_mem = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("halt_flag",  64'(bus.halt),       64'(1));
      chk("halt_phase", 64'(bus.phase),      64'(0));
      chk("halt_rd_en", 64'(bus.imem_rd_en), 64'(0));
      chk("halt_req",   64'(bus.mem_req),    64'(0));
      chk("halt_ret",   64'(bus.retired),    64'(3));
      chk("halt_ir",    64'(bus.ir),         64'(0));
      bus.mem_ready = 1'($urandom);
      tick();
    end
    bus.is_mem = 1'b0;
    do_reset();
    chk("halt_cleared", 64'(bus.halt), 64'(0));

    // Branch resolution at pc=4.
    run_instr(1'b1, BR_BEQ, 4, 1'b0, 0, cyc, req);
    chk("goto4", 64'(bus.imem_addr), 64'(4));
    run_instr(1'b1, BR_BEQ, -2, 1'b0, 0, cyc, req);
    chk("beq_taken", 64'(bus.imem_addr), 64'(2));
    run_instr(1'b1, BR_BNE, 2, 1'b0, 0, cyc, req);
    run_instr(1'b0, BR_BEQ, -2, 1'b0, 0, cyc, req);
    chk("beq_not_taken", 64'(bus.imem_addr), 64'(5));
    run_instr(1'b1, BR_NONE, 9, 1'b0, 0, cyc, req);
    chk("sel7_no_redirect", 64'(bus.imem_addr), 64'(6));
    run_instr(1'b1, 3'd5, 9, 1'b0, 0, cyc, req);
    chk("sel5_no_redirect", 64'(bus.imem_addr), 64'(7));

    // Load with three stall cycles, then a load with no stall.
    run_instr(1'b0, BR_NONE, 0, 1'b1, 3, cyc, req);
    chk("load_cycles", 64'(cyc), 64'(8));
    chk("load_reqs",   64'(req), 64'(4));
    run_instr(1'b0, BR_NONE, 0, 1'b1, 0, cyc, req);
    chk("load_nostall_cycles", 64'(cyc), 64'(5));
    chk("load_addr", 64'(bus.imem_addr), 64'(9));

    // Wrap cases.
    run_instr(1'b1, BR_BEQ, -9, 1'b0, 0, cyc, req);
    run_instr(1'b1, BR_BEQ, -1, 1'b0, 0, cyc, req);
    chk("at31", 64'(bus.imem_addr), 64'(31));
    run_instr(1'b0, BR_NONE, 0, 1'b0, 0, cyc, req);
    chk("wrap_seq", 64'(bus.imem_addr), 64'(0));
    run_instr(1'b1, BR_BLT, -2, 1'b0, 0, cyc, req);
    chk("at30", 64'(bus.imem_addr), 64'(30));
    run_instr(1'b1, BR_BGE, 5, 1'b0, 0, cyc, req);
    chk("wrap_fwd", 64'(bus.imem_addr), 64'(3));
    run_instr(1'b1, BR_BNE, -3, 1'b0, 0, cyc, req);
    run_instr(1'b1, BR_BNE, -33, 1'b0, 0, cyc, req);
    chk("wrap_neg", 64'(bus.imem_addr), 64'(31));
    run_instr(1'b1, BR_BEQ, 0, 1'b0, 0, cyc, req);
    chk("loop_off0", 64'(bus.imem_addr), 64'(31));

    // Randomized instruction stream against the model.
    for (int n = 0; n < 40; n++) begin
      sel = 3'($urandom);
      off = int'($urandom_range(80)) - 40;
      run_instr(1'($urandom), sel, off, 1'($urandom), int'($urandom_range(3)), cyc, req);
    end
    chk("rand_retired", 64'(bus.retired), 64'(ret_m));
    chk("rand_addr",    64'(bus.imem_addr), 64'(pc_m));

    // Reset in the middle of a MEM stall.
    imem[pc_m] = 32'h0000_0033;
    bus.is_mem = 1'b1;
    bus.mem_ready = 1'b0;
    tick(); tick(); tick();
    chk("stall_req0", 64'(bus.mem_req), 64'(1));
    tick();
    chk("stall_req1", 64'(bus.mem_req), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_phase",   64'(bus.phase),     64'(5'b00001));
    chk("mrst_addr",    64'(bus.imem_addr), 64'(0));
    chk("mrst_mem_req", 64'(bus.mem_req),   64'(0));
    chk("mrst_retired", 64'(bus.retired),   64'(0));
    bus.is_mem = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
